// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: parses set-2 PS/2 scan-code bytes (E0 / F0 / E1 Pause),
// keeps a table of held keys with typematic-repeat suppression and queues
// clean make/break events in a small valid/ready FIFO.
module ps2_key_tracker #(
  parameter int NSLOTS     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1,
  localparam int CW = $clog2(NSLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_make,
  output logic [8:0]        ev_code,
  output logic [SW-1:0]     ev_slot,
  output logic [NSLOTS-1:0] held_mask,
  output logic [CW-1:0]     held_count,
  output logic              ovf,
  output logic              drop,
  input  logic              clr_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + 9 + SW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  skip_cnt;
  logic [2:0]  skip_nxt;

  logic        is_e0;
  logic        is_f0;
  logic        is_e1;
  logic        is_fake_shift;
  logic        is_ignored;

  logic        key_make;
  logic        key_brk;
  logic        key_ext;
  logic [8:0]  key_code;

  logic [8:0]  slot_code [NSLOTS];
  logic        hit;
  logic [SW-1:0] hit_idx;
  logic        free_ok;
  logic [SW-1:0] free_idx;

  logic        alloc;
  logic        release_key;
  logic        table_full_make;
  logic        push;
  logic [EW-1:0] push_entry;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          push_lost;
  logic [EW-1:0] head;

  assign is_e0         = (byte_data == 8'hE0);
  assign is_f0         = (byte_data == 8'hF0);
  assign is_e1         = (byte_data == 8'hE1);
  assign is_fake_shift = (byte_data == 8'h12) || (byte_data == 8'h59);

  // Receiver status / ack bytes that never carry a key in the idle state
  always_comb begin
    is_ignored = 1'b0;
    case (byte_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default: is_ignored = 1'b0;
    endcase
  end

  // Parser state and Pause skip counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Parser next state; only advances on a received byte
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    if (byte_valid) begin
      case (state)
        S_IDLE: begin
          if (is_e0) begin
            state_nxt = S_EXT;
          end else if (is_f0) begin
            state_nxt = S_BRK;
          end else if (is_e1) begin
            state_nxt = S_PAUSE;
            skip_nxt  = 3'd7;
          end
        end
        S_EXT:     state_nxt = is_f0 ? S_EXT_BRK : S_IDLE;
        S_BRK:     state_nxt = S_IDLE;
        S_EXT_BRK: state_nxt = S_IDLE;
        S_PAUSE: begin
          if (skip_cnt <= 3'd1) begin
            skip_nxt  = 3'd0;
            state_nxt = S_IDLE;
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          skip_nxt  = 3'd0;
        end
      endcase
    end
  end

  // Parser outputs: which key action the current byte completes
  always_comb begin
    key_make = 1'b0;
    key_brk  = 1'b0;
    key_ext  = 1'b0;
    if (byte_valid) begin
      case (state)
        S_IDLE:    key_make = !is_e0 && !is_f0 && !is_e1 && !is_ignored;
        S_EXT: begin
          key_make = !is_f0 && !is_fake_shift;
          key_ext  = 1'b1;
        end
        S_BRK:     key_brk = 1'b1;
        S_EXT_BRK: begin
          key_brk = 1'b1;
          key_ext = 1'b1;
        end
        default: begin
          key_make = 1'b0;
          key_brk  = 1'b0;
        end
      endcase
    end
  end

  assign key_code = {key_ext, byte_data};

  // Parallel lookup of the key and of the lowest free slot
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (held_mask[i] && (slot_code[i] == key_code)) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
      if (!held_mask[i]) begin
        free_ok  = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  assign alloc           = key_make && !hit && free_ok;
  assign table_full_make = key_make && !hit && !free_ok;
  assign release_key     = key_brk && hit;
  assign push            = alloc || release_key;
  assign push_entry      = {alloc, key_code, alloc ? free_idx : hit_idx};

  // Slot occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      held_mask <= '0;
    end else if (alloc) begin
      held_mask[free_idx] <= 1'b1;
    end else if (release_key) begin
      held_mask[hit_idx] <= 1'b0;
    end
  end

  // Slot key codes; only meaningful where held_mask is set
  always_ff @(posedge clk) begin
    if (alloc) begin
      slot_code[free_idx] <= key_code;
    end
  end

  // Popcount of the occupancy mask
  always_comb begin
    held_count = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      held_count = held_count + CW'(held_mask[i]);
    end
  end

  assign ev_valid  = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = ev_valid && ev_ready;
  assign push_ok   = push && (!fifo_full || pop);
  assign push_lost = push && fifo_full && !pop;

  // Event FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Event FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // Head fields read as zero while the FIFO is empty
  assign head    = fifo_mem[rd_ptr[AW-1:0]];
  assign ev_make = ev_valid & head[EW-1];
  assign ev_code = ev_valid ? head[EW-2 -: 9] : 9'd0;
  assign ev_slot = ev_valid ? head[SW-1:0] : '0;

  // Sticky error flags; a clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst || clr_flags) begin
      ovf  <= 1'b0;
      drop <= 1'b0;
    end else begin
      if (table_full_make) ovf  <= 1'b1;
      if (push_lost)       drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with NSLOTS=8, FIFO_DEPTH=4.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       clr_flags = 1'b0;
  logic       ev_valid;
  logic       ev_make;
  logic [8:0] ev_code;
  logic [2:0] ev_slot;
  logic [7:0] held_mask;
  logic [3:0] held_count;
  logic       ovf;
  logic       drop;

  int total = 0;
  int bad   = 0;

  ps2_key_tracker #(.NSLOTS(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_make    (ev_make),
    .ev_code    (ev_code),
    .ev_slot    (ev_slot),
    .held_mask  (held_mask),
    .held_count (held_count),
    .ovf        (ovf),
    .drop       (drop),
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; byte_valid = 1'b0; ev_ready = 1'b0; clr_flags = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_data = 8'h00;
  endtask

  task automatic pop_head(output logic [13:0] e);
    e = {ev_valid, ev_make, ev_code, ev_slot};
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] all;
    rst = 1'b1;
    @(posedge clk); #1;
    all = {ev_valid, ev_make, ev_code, ev_slot, held_mask, held_count, ovf, drop};
    total++; if (all !== 28'd0) begin bad++; $display("FAIL reset_vals got=%h want=%h", all, 28'd0); end
    rst = 1'b0;
    @(posedge clk); #1;
    all = {ev_valid, ev_make, ev_code, ev_slot, held_mask, held_count, ovf, drop};
    total++; if (all !== 28'd0) begin bad++; $display("FAIL reset_idle got=%h want=%h", all, 28'd0); end
  endtask

  task automatic test_basic();
    logic [13:0] e;
    do_reset();
    ev_ready = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h1C;
    #1;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL lat_pre got=%b want=0", ev_valid); end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    e = {ev_valid, ev_make, ev_code, ev_slot};
    total++; if (e !== {1'b1, 1'b1, 9'h01C, 3'd0}) begin bad++; $display("FAIL basic_make got=%h want=%h", e, {1'b1, 1'b1, 9'h01C, 3'd0}); end
    total++; if (held_mask !== 8'h01) begin bad++; $display("FAIL basic_mask1 got=%h want=01", held_mask); end
    send(8'hF0);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL basic_f0 got=%b want=0", ev_valid); end
    send(8'h1C);
    e = {ev_valid, ev_make, ev_code, ev_slot};
    total++; if (e !== {1'b1, 1'b0, 9'h01C, 3'd0}) begin bad++; $display("FAIL basic_brk got=%h want=%h", e, {1'b1, 1'b0, 9'h01C, 3'd0}); end
    total++; if (held_mask !== 8'h00) begin bad++; $display("FAIL basic_mask0 got=%h want=00", held_mask); end
    @(posedge clk); #1;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_typematic();
    logic [13:0] e;
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'h1B); send(8'hF0); send(8'h1C);
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01C, 3'd0}) begin bad++; $display("FAIL typ_ev0 got=%h want=%h", e, {1'b1, 1'b1, 9'h01C, 3'd0}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01B, 3'd1}) begin bad++; $display("FAIL typ_ev1 got=%h want=%h", e, {1'b1, 1'b1, 9'h01B, 3'd1}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b0, 9'h01C, 3'd0}) begin bad++; $display("FAIL typ_ev2 got=%h want=%h", e, {1'b1, 1'b0, 9'h01C, 3'd0}); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL typ_empty got=%b want=0", ev_valid); end
    total++; if (held_mask !== 8'h02) begin bad++; $display("FAIL typ_mask got=%h want=02", held_mask); end
  endtask

  task automatic test_extended();
    logic [13:0] e;
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    send(8'hAA); send(8'hFA);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h175, 3'd0}) begin bad++; $display("FAIL ext_make got=%h want=%h", e, {1'b1, 1'b1, 9'h175, 3'd0}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b0, 9'h175, 3'd0}) begin bad++; $display("FAIL ext_brk got=%h want=%h", e, {1'b1, 1'b0, 9'h175, 3'd0}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01C, 3'd0}) begin bad++; $display("FAIL ext_idle_after got=%h want=%h", e, {1'b1, 1'b1, 9'h01C, 3'd0}); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ext_empty got=%b want=0", ev_valid); end
    total++; if (held_mask !== 8'h01) begin bad++; $display("FAIL ext_mask got=%h want=01", held_mask); end
  endtask

  task automatic test_table_full();
    logic [13:0] e;
    logic [7:0]  keys [8];
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(keys[i]);
      pop_head(e);
      total++; if (e !== {1'b1, 1'b1, 1'b0, keys[i], 3'(i)}) begin bad++; $display("FAIL full_make%0d got=%h want=%h", i, e, {1'b1, 1'b1, 1'b0, keys[i], 3'(i)}); end
    end
    total++; if (held_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", held_count); end
    total++; if (held_mask !== 8'hFF) begin bad++; $display("FAIL full_mask got=%h want=ff", held_mask); end
    send(8'h44);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL full_noev got=%b want=0", ev_valid); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b want=1", ovf); end
    send(8'hF0); send(8'h2D);
    pop_head(e);
    total++; if (e !== {1'b1, 1'b0, 9'h02D, 3'd3}) begin bad++; $display("FAIL full_rel got=%h want=%h", e, {1'b1, 1'b0, 9'h02D, 3'd3}); end
    send(8'h4D);
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h04D, 3'd3}) begin bad++; $display("FAIL full_reuse got=%h want=%h", e, {1'b1, 1'b1, 9'h04D, 3'd3}); end
    clr_flags = 1'b1;
    send(8'h44);
    clr_flags = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL clr_prio got=%b want=0", ovf); end
    send(8'h44);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_reset got=%b want=1", ovf); end
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf); end
  endtask

  task automatic test_fifo_full();
    logic [13:0] e;
    do_reset();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL ff_drop got=%b want=1", drop); end
    total++; if (held_count !== 4'd6) begin bad++; $display("FAIL ff_count got=%0d want=6", held_count); end
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    e = {ev_valid, ev_make, ev_code, ev_slot};
    total++; if (e !== {1'b1, 1'b1, 9'h015, 3'd0}) begin bad++; $display("FAIL ff_head_stable got=%h want=%h", e, {1'b1, 1'b1, 9'h015, 3'd0}); end
    ev_ready = 1'b1;
    send(8'h3C);
    ev_ready = 1'b0;
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL ff_pushpop_drop got=%b want=0", drop); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01D, 3'd1}) begin bad++; $display("FAIL ff_ev1 got=%h want=%h", e, {1'b1, 1'b1, 9'h01D, 3'd1}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h024, 3'd2}) begin bad++; $display("FAIL ff_ev2 got=%h want=%h", e, {1'b1, 1'b1, 9'h024, 3'd2}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h02D, 3'd3}) begin bad++; $display("FAIL ff_ev3 got=%h want=%h", e, {1'b1, 1'b1, 9'h02D, 3'd3}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h03C, 3'd6}) begin bad++; $display("FAIL ff_ev4 got=%h want=%h", e, {1'b1, 1'b1, 9'h03C, 3'd6}); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ff_empty got=%b want=0", ev_valid); end
    total++; if (held_count !== 4'd7) begin bad++; $display("FAIL ff_count7 got=%0d want=7", held_count); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01C, 3'd0}) begin bad++; $display("FAIL b2b_ev0 got=%h want=%h", e, {1'b1, 1'b1, 9'h01C, 3'd0}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b0, 9'h01C, 3'd0}) begin bad++; $display("FAIL b2b_ev1 got=%h want=%h", e, {1'b1, 1'b0, 9'h01C, 3'd0}); end
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01C, 3'd0}) begin bad++; $display("FAIL b2b_ev2 got=%h want=%h", e, {1'b1, 1'b1, 9'h01C, 3'd0}); end
    total++; if (held_mask !== 8'h01) begin bad++; $display("FAIL b2b_mask got=%h want=01", held_mask); end
  endtask

  task automatic test_reset_midseq();
    logic [13:0] e;
    logic [27:0] all;
    do_reset();
    send(8'h15);
    send(8'hE0); send(8'hF0);
    rst = 1'b1;
    @(posedge clk); #1;
    all = {ev_valid, ev_make, ev_code, ev_slot, held_mask, held_count, ovf, drop};
    total++; if (all !== 28'd0) begin bad++; $display("FAIL rst_during got=%h want=%h", all, 28'd0); end
    rst = 1'b0;
    @(posedge clk); #1;
    all = {ev_valid, ev_make, ev_code, ev_slot, held_mask, held_count, ovf, drop};
    total++; if (all !== 28'd0) begin bad++; $display("FAIL rst_after got=%h want=%h", all, 28'd0); end
    send(8'h1C);
    pop_head(e);
    total++; if (e !== {1'b1, 1'b1, 9'h01C, 3'd0}) begin bad++; $display("FAIL rst_first got=%h want=%h", e, {1'b1, 1'b1, 9'h01C, 3'd0}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_typematic();
    test_extended();
    test_table_full();
    test_fifo_full();
    test_back_to_back();
    test_reset_midseq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Polyphonic PS/2 scan-code tracker placed between the PS/2 byte receiver and the note engine. It parses set-2 scan-code bytes (E0 extended prefix, F0 break prefix, E1 Pause sequence), keeps a table of currently held keys, and suppresses typematic repeats. It emits clean make/break events through a valid/ready FIFO. Unlike the single-keycode front end, it tracks up to NSLOTS simultaneous keys, so releasing one key never re-triggers another.

## Interface
- NSLOTS, 8: held-key table entries (1..16).
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).
- SW, clog2(NSLOTS) (min 1): slot index width (derived).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- byte_valid  in  1  one-cycle strobe: byte_data holds a received PS/2 byte.
- byte_data  in  8  received scan-code byte.
- ev_valid  out  1  FIFO head is valid.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_make  out  1  1 = press, 0 = release (head).
- ev_code  out  9  {extended, code[7:0]} (head).
- ev_slot  out  SW  table slot of the key (head).
- held_mask  out  NSLOTS  bit i = slot i occupied.
- held_count  out  clog2(NSLOTS+1)  popcount of held_mask.
- ovf  out  1  sticky: a make was dropped because the table was full.
- drop  out  1  sticky: an event was lost because the FIFO was full.
- clr_flags  in  1  synchronous clear of ovf and drop.

## Operation
- Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (skipping bytes).
- FSM acts only in cycles with byte_valid=1.
- IDLE transitions:
  - E0 → EXT; F0 → BRK; E1 → PAUSE, skip counter = 7.
  - 00, AA, EE, FA, FC, FD, FE, FF → ignored, stay in IDLE.
  - Any other byte → make, ext=0.
- EXT: F0 → EXT_BRK; 12 or 59 (fake shift) → IDLE, no event; other → make, ext=1.
- BRK: byte → break, ext=0 → IDLE. EXT_BRK: byte → break, ext=1 → IDLE.
- PAUSE: decrement the counter on each byte; return to IDLE when it reaches 0. No event.
- Make handling:
  - Code already in the table (typematic repeat) → no event, no change.
  - Otherwise allocate the lowest free slot and push {1, code, slot}.
  - Table full → set ovf; no event, no change.
- Break handling:
  - Code found in the table → free that slot and push {0, code, slot}.
  - Code not found → no event, no flag.
- Table lookup: parallel compare over all slots. At most one match is possible by construction.
- FIFO full on push:
  - The table is still updated; the event is discarded and drop is set.
  - Exception: if ev_ready=1 in the same cycle, the pop frees space and the push succeeds.
- held_count is derived combinationally from registered held_mask.
- clr_flags takes priority over a same-cycle set.

## Timing
- Reset values: FSM=IDLE, skip counter=0, table empty, held_mask=0, held_count=0, FIFO empty, ev_valid=0, ev_make=0, ev_code=0, ev_slot=0, ovf=0, drop=0.
- rst asserted mid-sequence (for example after E0 F0) drops the partial sequence. The first byte after reset is parsed from IDLE.
- Latency: the final byte of a sequence is presented in cycle t. held_mask and the FIFO entry update at the clk edge ending cycle t, so ev_valid=1 from cycle t+1 when the FIFO was empty.
- Back-to-back byte_valid on every cycle is supported. Each byte is processed in its own cycle, with no stall and no input ready.
- Handshake:
  - Pop occurs on any cycle with ev_valid && ev_ready.
  - ev_make, ev_code and ev_slot stay stable while ev_valid=1 and ev_ready=0.
  - ev_ready while empty has no effect.
- The FIFO wraps read and write pointers modulo FIFO_DEPTH. Full/empty use an extra pointer bit.
- A make and a break of the same key in consecutive cycles are both applied in order. The freed slot is reusable on the next cycle.

## Test plan
- 1C, then F0 1C, each byte one cycle apart, ev_ready=1:
  - Events {make,0x01C,slot0}, then {break,0x01C,slot0}.
  - held_mask goes 0x01 → 0x00.
  - ev_valid rises exactly one cycle after the final byte.
- Hold 1C (typematic 1C 1C 1C), press 1B, release with F0 1C:
  - Only make 1C(slot0), make 1B(slot1), break 1C(slot0).
  - held_mask ends 0x02; 1B is not re-emitted.
- E0 75, E0 F0 75, plus E0 12 and E1 14 77 E1 F0 14 F0 77:
  - Events {make,0x175} and {break,0x175} only.
  - Fake shift and Pause produce nothing; FSM ends in IDLE.
- Press 9 distinct keys with NSLOTS=8:
  - 8 makes in slots 0..7; held_count=8; ninth key gives no event and ovf=1.
  - Release slot 3's key, then press a new key → new key lands in slot 3.
  - clr_flags → ovf=0.
- ev_ready=0 with 6 makes, FIFO_DEPTH=4:
  - 4 events retained in order, drop=1, held_count=6.
  - Then ev_ready=1 with a simultaneous push at full → push succeeds.
- rst pulsed after E0 F0, then 1C:
  - Make 0x01C (not break 0x11C).
  - All outputs at reset values during and one cycle after rst.
